uart_sample_framer: RTL
=======================

Name: uart_sample_framer

Overview:
Upstream feeder for the UART transmitter. Captures one multi-channel hydrophone sample word per frame and serialises it into a byte frame: sync byte, sequence byte, channel bytes MSB-first, and an optional checksum. Drives the UART TX byte handshake (TX_Data_in / TX_en / TX_Ready_To_Send) so sample data reaches the topside host over the serial link.

Parameters:
NUM_CH, 4, number of channels packed in Sample_data
SAMPLE_W, 16, bits per channel sample (1..32)
SYNC_BYTE, 8'hA5, first byte of every frame
DROP_CNT_W, 16, width of the saturating dropped-sample counter

Ports:
clk  in  1  system clock
reset_b  in  1  synchronous active-low reset
Sample_valid  in  1  sample word present
Sample_data  in  NUM_CH*SAMPLE_W  channel 0 in LSBs
Sample_ready  out  1  framer idle; sample accepted when valid&&ready
TX_Data  out  8  byte to UART (connects to TX_Data_in)
TX_en  out  1  byte request to UART
TX_Ready_To_Send  in  1  UART TX idle (UART_clk domain)
Frame_busy  out  1  frame in progress
Drop_count  out  DROP_CNT_W  samples offered while busy, saturating

Behaviour:
- Interface: one clock (clk); reset_b is synchronous, active-low.
- Reset values: TX_en=0, TX_Data=0, Frame_busy=0, Drop_count=0, seq=0, state IDLE, so Sample_ready=1.
- TX_Ready_To_Send passes through a 2-flop synchroniser. All decisions use the synchronised copy (rdy_s), adding 2 cycles of latency.
- BPS = ceil(SAMPLE_W/8). Each channel is zero-extended to BPS*8 bits and sent MSB byte first, channel 0 first.
- Frame = SYNC, SEQ, NUM_CH*BPS sample bytes, [CHK]. With defaults this is 10 bytes, or 11 with the checksum.
- Sample_ready is combinational: (state==IDLE).
  - Capture on valid&&ready. The word is registered, and the next cycle state=LOAD and Frame_busy=1.
- States:
  - IDLE: wait for capture.
  - LOAD: byte index=0, go ISSUE.
  - ISSUE: when rdy_s=1, drive TX_Data=byte[idx] and TX_en=1, go HOLD.
  - HOLD: TX_en and TX_Data held stable until rdy_s=0 is seen. Then TX_en=0 on the next edge, go GAP.
  - GAP: wait for rdy_s=1. If idx is the last byte, go IDLE, Frame_busy=0, and seq increments (255 wraps to 0). Otherwise idx++ and go ISSUE.
- Handshake rules:
  - Exactly one byte per TX_en assertion.
  - TX_en never rises while rdy_s=0.
  - There is no timeout; HOLD waits indefinitely for the UART.
- Drop_count increments on every cycle with Sample_valid && !Sample_ready and saturates at all-ones. Accepted samples never count.
- Back-to-back frames: Sample_ready rises the cycle state returns to IDLE. A sample accepted in that cycle starts LOAD next cycle.
- Reset mid-frame: on the next edge TX_en=0, state IDLE, seq=0, Drop_count=0. The partial frame is abandoned and never resumed.

Optional Feature:
FRAMER_CHECKSUM_EN:
- Defined: CHK is appended as the last byte. CHK = mod-256 sum of SEQ and all sample bytes; SYNC is excluded. It is accumulated as each byte enters ISSUE and cleared in LOAD.
- Undefined: no accumulator logic; the frame ends after the last sample byte.

Decomposition:
- Package uart_framer_pkg holds:
  - the state enum (IDLE, LOAD, ISSUE, HOLD, GAP);
  - the default SYNC_BYTE constant;
  - a bytes_per_sample(SAMPLE_W) function;
  - a frame_len(NUM_CH, BPS, chk) function.
- One sub-module, ready_sync: a 2-flop synchroniser, reused for any UART_clk-to-clk single-bit status.

Test Plan:
- Checksum frame: macro defined, samples ch0..3 = 0x1234, 0x5678, 0x9ABC, 0xDEF0; UART model acks each byte -> bytes A5 00 12 34 56 78 9A BC DE F0 38, then Sample_ready=1.
- Sequence wrap: 257 consecutive frames -> SEQ runs 00..FF then 00; Drop_count stays 0 when valid is only offered while ready.
- Dropped samples: Sample_valid held high for 5 cycles while Frame_busy=1 -> Drop_count=5 and the in-flight frame is unchanged. Preload Drop_count to all-ones -> it stays all-ones.
- Slow UART: model drops ready 10 cycles after TX_en and stays busy 40 cycles ->
  - TX_en held until the drop is seen;
  - TX_Data stable throughout;
  - no second TX_en before ready returns;
  - exactly 11 bytes received.
- Mid-frame reset: reset_b=0 for 1 cycle after byte 4 is issued -> next cycle TX_en=0 and Sample_ready=1; next frame begins A5 00.
- Checksum compiled out: macro undefined, same stimulus as the checksum frame -> 10 bytes ending F0; idle 2+ cycles after the last byte with no further TX_en.

Source files
------------

// File: rtl/uart_framer_pkg.sv
// Shared types and sizing helpers for the UART sample framer.
package uart_framer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ISSUE = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } framer_state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    function automatic int bytes_per_sample(input int sample_w);
        return (sample_w + 7) / 8;
    endfunction

    function automatic int frame_len(input int num_ch, input int bps, input bit chk);
        return 2 + num_ch * bps + (chk ? 1 : 0);
    endfunction

endpackage

// File: rtl/uart_sample_framer_ready_sync.sv
// Two-flop synchroniser for a single UART_clk-domain status bit into clk.
module ready_sync (
    input  logic clk,
    input  logic reset_b,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/uart_sample_framer.sv
// Captures one multi-channel sample word and feeds it byte-by-byte to the UART TX.
// Optional trailing checksum byte is enabled by defining FRAMER_CHECKSUM_EN.
module uart_sample_framer
    import uart_framer_pkg::*;
#(
    parameter int         NUM_CH     = 4,
    parameter int         SAMPLE_W   = 16,
    parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE,
    parameter int         DROP_CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       reset_b,
    input  logic                       Sample_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0] Sample_data,
    output logic                       Sample_ready,
    output logic [7:0]                 TX_Data,
    output logic                       TX_en,
    input  logic                       TX_Ready_To_Send,
    output logic                       Frame_busy,
    output logic [DROP_CNT_W-1:0]      Drop_count,
    output logic [2:0]                 state_dbg
);

    // Byte handshake: TX_en rises only while rdy_s=1, then TX_en/TX_Data stay
    // frozen until the UART drops rdy_s; the next byte waits for rdy_s to return.

    localparam int BPS = bytes_per_sample(SAMPLE_W);
`ifdef FRAMER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif
    localparam int NUM_SB    = NUM_CH * BPS;
    localparam int FRAME_LEN = frame_len(NUM_CH, BPS, CHK_EN);
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    framer_state_t              state, state_d;
    logic                       rdy_s;
    logic [NUM_CH*SAMPLE_W-1:0] sample_q;
    logic [IDX_W-1:0]           idx;
    logic [IDX_W-1:0]           sb_idx;
    logic [7:0]                 seq;
    logic [7:0]                 cur_byte;
    logic [BPS*8-1:0]           ch_ext;
    logic [7:0]                 sample_bytes [NUM_SB];
`ifdef FRAMER_CHECKSUM_EN
    logic [7:0]                 chk_acc;
`endif

    ready_sync u_ready_sync (
        .clk      (clk),
        .reset_b  (reset_b),
        .async_in (TX_Ready_To_Send),
        .sync_out (rdy_s)
    );

    assign Sample_ready = (state == IDLE);
    assign state_dbg    = state;

    // Zero-extend each channel to whole bytes, MSB byte first, channel 0 first.
    always_comb begin
        ch_ext = '0;
        for (int k = 0; k < NUM_SB; k++) sample_bytes[k] = 8'h00;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            ch_ext = '0;
            ch_ext[SAMPLE_W-1:0] = sample_q[ch*SAMPLE_W +: SAMPLE_W];
            for (int b = 0; b < BPS; b++) begin
                sample_bytes[ch*BPS + b] = ch_ext[(BPS-1-b)*8 +: 8];
            end
        end
    end

    always_comb begin
        sb_idx   = idx - IDX_W'(2);
        cur_byte = 8'h00;
        if (idx == '0) begin
            cur_byte = SYNC_BYTE;
        end else if (idx == IDX_W'(1)) begin
            cur_byte = seq;
`ifdef FRAMER_CHECKSUM_EN
        end else if (idx == LAST_IDX) begin
            cur_byte = chk_acc;
`endif
        end else begin
            for (int k = 0; k < NUM_SB; k++) begin
                if (sb_idx == IDX_W'(k)) cur_byte = sample_bytes[k];
            end
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (Sample_valid) state_d = LOAD;
            LOAD:    state_d = ISSUE;
            ISSUE:   if (rdy_s) state_d = HOLD;
            HOLD:    if (!rdy_s) state_d = GAP;
            GAP:     if (rdy_s) state_d = (idx == LAST_IDX) ? IDLE : ISSUE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state      <= IDLE;
            sample_q   <= '0;
            idx        <= '0;
            seq        <= 8'h00;
            TX_Data    <= 8'h00;
            TX_en      <= 1'b0;
            Frame_busy <= 1'b0;
            Drop_count <= '0;
`ifdef FRAMER_CHECKSUM_EN
            chk_acc    <= 8'h00;
`endif
        end else begin
            state <= state_d;
            case (state)
                IDLE: begin
                    if (Sample_valid) begin
                        sample_q   <= Sample_data;
                        Frame_busy <= 1'b1;
                    end
                end
                LOAD: begin
                    idx <= '0;
`ifdef FRAMER_CHECKSUM_EN
                    chk_acc <= 8'h00;
`endif
                end
                ISSUE: begin
                    if (rdy_s) begin
                        TX_Data <= cur_byte;
                        TX_en   <= 1'b1;
`ifdef FRAMER_CHECKSUM_EN
                        // SYNC and the checksum byte itself stay out of the sum.
                        if (idx != '0 && idx != LAST_IDX) chk_acc <= chk_acc + cur_byte;
`endif
                    end
                end
                HOLD: begin
                    if (!rdy_s) TX_en <= 1'b0;
                end
                GAP: begin
                    if (rdy_s) begin
                        if (idx == LAST_IDX) begin
                            Frame_busy <= 1'b0;
                            seq        <= seq + 8'd1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
            if (Sample_valid && !Sample_ready && Drop_count != '1) begin
                Drop_count <= Drop_count + DROP_CNT_W'(1);
            end
        end
    end

endmodule
